// File: rtl/fpu_arbiter_if.sv
// FPU operation encoding plus the requester/FPU bundle for fpu_arbiter.
// The arbiter takes the slave side; requesters and the FPU take the master side.
package pa_fpu;
  typedef enum logic [2:0] {
    op_add  = 3'd0,
    op_sub  = 3'd1,
    op_mul  = 3'd2,
    op_div  = 3'd3,
    op_sqrt = 3'd4
  } e_fpu_op;
endpackage

interface fpu_arbiter_if #(
  parameter int N = 4
);
  import pa_fpu::*;

  logic [N-1:0]         req_valid;
  logic [N-1:0][31:0]   req_a;
  logic [N-1:0][31:0]   req_b;
  e_fpu_op [N-1:0]      req_op;
  logic [N-1:0]         req_grant;
  logic [N-1:0]         req_done;
  logic                 req_error;
  logic [31:0]          result;
  logic                 fpu_start;
  logic [31:0]          fpu_a;
  logic [31:0]          fpu_b;
  e_fpu_op              fpu_op;
  logic [31:0]          fpu_result;
  logic                 fpu_cmd_end;
  logic                 fpu_busy;

  modport master (
    output req_valid, req_a, req_b, req_op,
    output fpu_result, fpu_cmd_end, fpu_busy,
    input  req_grant, req_done, req_error, result,
    input  fpu_start, fpu_a, fpu_b, fpu_op
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  fpu_result, fpu_cmd_end, fpu_busy,
    output req_grant, req_done, req_error, result,
    output fpu_start, fpu_a, fpu_b, fpu_op
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU among N requesters,
// with a watchdog that aborts operations whose cmd_end never arrives.
module fpu_arbiter
  import pa_fpu::*;
#(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 256,
  localparam int PTR_W   = $clog2(N)
) (
  input logic        clk,
  input logic        arst,
  fpu_arbiter_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ABORT
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] nxt_ptr;
  logic             found;
  logic [WD_W-1:0]  wd;

  // first requesting index at or after ptr, wrapping mod N
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign nxt_ptr = (owner == PTR_W'(N - 1)) ? '0 : owner + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (arst) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      wd            <= '0;
      bus.req_grant <= '0;
      bus.req_done  <= '0;
      bus.req_error <= 1'b0;
      bus.result    <= '0;
      bus.fpu_start <= 1'b0;
      bus.fpu_a     <= '0;
      bus.fpu_b     <= '0;
      bus.fpu_op    <= op_add;
    end else begin
      unique case (state)
        IDLE: begin
          bus.req_done  <= '0;
          bus.req_error <= 1'b0;
          if (found && !bus.fpu_busy) begin
            owner         <= sel;
            bus.req_grant <= ONE << sel;
            bus.fpu_a     <= bus.req_a[sel];
            bus.fpu_b     <= bus.req_b[sel];
            bus.fpu_op    <= bus.req_op[sel];
            bus.fpu_start <= 1'b1;
            wd            <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          // cmd_end wins over a timeout landing in the same cycle
          if (bus.fpu_cmd_end) begin
            bus.result    <= bus.fpu_result;
            bus.fpu_start <= 1'b0;
            bus.req_done  <= bus.req_grant;
            bus.req_error <= 1'b0;
            state         <= DONE;
          end else if (wd == WD_LAST) begin
            bus.result    <= QNAN;
            bus.fpu_start <= 1'b0;
            bus.req_done  <= bus.req_grant;
            bus.req_error <= 1'b1;
            state         <= ABORT;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        DONE, ABORT: begin
          bus.req_done  <= '0;
          bus.req_error <= 1'b0;
          bus.req_grant <= '0;
          ptr           <= nxt_ptr;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter; the bench plays both the
// requesters and a hand-driven FPU stub.
module tb_fpu_arbiter;
  import pa_fpu::*;

  logic clk = 1'b0;
  logic arst;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpu_arbiter_if #(.N(4)) bus ();

  fpu_arbiter #(
    .N(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .arst(arst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = {4{op_add}};
    bus.fpu_result = '0;
    bus.fpu_cmd_end = 1'b0;
    bus.fpu_busy = 1'b0;
    tick();
    tick();
    total++;
    if (bus.req_grant !== 4'b0000) begin
      bad++;
      $display("FAIL reset_grant got=%b want=0000", bus.req_grant);
    end
    total++;
    if (bus.req_done !== 4'b0000 || bus.req_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b/%b want=0000/0", bus.req_done, bus.req_error);
    end
    total++;
    if (bus.fpu_start !== 1'b0 || bus.result !== 32'h0) begin
      bad++;
      $display("FAIL reset_start_result got=%b/%h want=0/0", bus.fpu_start, bus.result);
    end
    total++;
    if (bus.fpu_a !== 32'h0 || bus.fpu_b !== 32'h0 || bus.fpu_op !== op_add) begin
      bad++;
      $display("FAIL reset_operands got=%h/%h/%0d want=0/0/0", bus.fpu_a, bus.fpu_b, bus.fpu_op);
    end
    arst = 1'b0;
    tick();
    total++;
    if (bus.req_grant !== 4'b0000) begin
      bad++;
      $display("FAIL idle_no_req got=%b want=0000", bus.req_grant);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i] = 32'h4180_0000;
      bus.req_b[i] = 32'h4200_0000;
      bus.req_op[i] = op_add;
    end
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int w = 0;
      exp = 4'b0001 << (k % 4);
      while (!bus.fpu_start && w < 10) begin
        tick();
        w++;
      end
      total++;
      if (bus.req_grant !== exp || bus.fpu_start !== 1'b1) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b start=%b want=%b", k, bus.req_grant, bus.fpu_start, exp);
      end
      tick();
      bus.fpu_cmd_end = 1'b1;
      bus.fpu_result = 32'h4240_0000;
      tick();
      bus.fpu_cmd_end = 1'b0;
      bus.fpu_result = '0;
      total++;
      if (bus.req_done !== exp || bus.result !== 32'h4240_0000) begin
        bad++;
        $display("FAIL rr_done%0d got=%b/%h want=%b/42400000", k, bus.req_done, bus.result, exp);
      end
      if (k == 4) bus.req_valid = '0;
      tick();
      total++;
      if (bus.req_done !== 4'b0000) begin
        bad++;
        $display("FAIL rr_single_pulse%0d got=%b want=0000", k, bus.req_done);
      end
    end
  endtask

  task automatic test_single();
    bus.req_a[0] = 32'h3f80_0000;
    bus.req_b[0] = 32'h3f8c_cccd;
    bus.req_op[0] = op_add;
    bus.req_valid = 4'b0001;
    tick();
    total++;
    if (bus.fpu_start !== 1'b1 || bus.req_grant !== 4'b0001) begin
      bad++;
      $display("FAIL single_issue got=%b/%b want=1/0001", bus.fpu_start, bus.req_grant);
    end
    total++;
    if (bus.fpu_a !== 32'h3f80_0000 || bus.fpu_b !== 32'h3f8c_cccd || bus.fpu_op !== op_add) begin
      bad++;
      $display("FAIL single_operands got=%h/%h/%0d want=3f800000/3f8ccccd/0", bus.fpu_a, bus.fpu_b, bus.fpu_op);
    end
    bus.req_valid = 4'b0000;
    tick();
    tick();
    total++;
    if (bus.fpu_start !== 1'b1 || bus.fpu_a !== 32'h3f80_0000) begin
      bad++;
      $display("FAIL single_hold got=%b/%h want=1/3f800000", bus.fpu_start, bus.fpu_a);
    end
    bus.fpu_cmd_end = 1'b1;
    bus.fpu_result = 32'h4006_6666;
    tick();
    bus.fpu_cmd_end = 1'b0;
    bus.fpu_result = '0;
    total++;
    if (bus.req_done !== 4'b0001 || bus.req_error !== 1'b0 || bus.fpu_start !== 1'b0) begin
      bad++;
      $display("FAIL single_done got=%b/%b/%b want=0001/0/0", bus.req_done, bus.req_error, bus.fpu_start);
    end
    total++;
    if (bus.result !== 32'h4006_6666) begin
      bad++;
      $display("FAIL single_result got=%h want=40066666", bus.result);
    end
    tick();
    total++;
    if (bus.req_done !== 4'b0000 || bus.req_grant !== 4'b0000 || bus.result !== 32'h4006_6666) begin
      bad++;
      $display("FAIL single_after got=%b/%b/%h want=0000/0000/40066666", bus.req_done, bus.req_grant, bus.result);
    end
  endtask

  task automatic test_rotation();
    bus.req_a[1] = 32'h3f80_0000;
    bus.req_b[1] = 32'h3f80_0000;
    bus.req_op[1] = op_add;
    bus.req_valid = 4'b0010;
    tick();
    total++;
    if (bus.req_grant !== 4'b0010) begin
      bad++;
      $display("FAIL rot_req1 got=%b want=0010", bus.req_grant);
    end
    bus.fpu_cmd_end = 1'b1;
    bus.fpu_result = 32'h4000_0000;
    tick();
    bus.fpu_cmd_end = 1'b0;
    bus.req_valid = 4'b0000;
    tick();
    bus.req_a[2] = 32'h3e80_0000;
    bus.req_b[2] = 32'h3f00_0000;
    bus.req_op[2] = op_sub;
    bus.req_a[0] = 32'h4040_0000;
    bus.req_b[0] = 32'h3f80_0000;
    bus.req_op[0] = op_mul;
    bus.req_valid = 4'b0101;
    tick();
    total++;
    if (bus.req_grant !== 4'b0100 || bus.fpu_a !== 32'h3e80_0000 || bus.fpu_op !== op_sub) begin
      bad++;
      $display("FAIL rot_req2_first got=%b/%h/%0d want=0100/3e800000/1", bus.req_grant, bus.fpu_a, bus.fpu_op);
    end
    bus.req_a[0] = 32'hdead_beef;
    tick();
    total++;
    if (bus.fpu_a !== 32'h3e80_0000 || bus.fpu_b !== 32'h3f00_0000) begin
      bad++;
      $display("FAIL rot_nonowner_ignored got=%h/%h want=3e800000/3f000000", bus.fpu_a, bus.fpu_b);
    end
    bus.fpu_cmd_end = 1'b1;
    bus.fpu_result = 32'hbe80_0000;
    tick();
    bus.fpu_cmd_end = 1'b0;
    total++;
    if (bus.req_done !== 4'b0100 || bus.result !== 32'hbe80_0000) begin
      bad++;
      $display("FAIL rot_sub_done got=%b/%h want=0100/be800000", bus.req_done, bus.result);
    end
    bus.req_valid = 4'b0001;
    tick();
    tick();
    total++;
    if (bus.req_grant !== 4'b0001 || bus.fpu_a !== 32'hdead_beef || bus.fpu_op !== op_mul) begin
      bad++;
      $display("FAIL rot_req0_next got=%b/%h/%0d want=0001/deadbeef/2", bus.req_grant, bus.fpu_a, bus.fpu_op);
    end
    bus.fpu_cmd_end = 1'b1;
    bus.fpu_result = 32'h4040_0000;
    tick();
    bus.fpu_cmd_end = 1'b0;
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    bus.req_a[3] = 32'h4000_0000;
    bus.req_b[3] = 32'h4000_0000;
    bus.req_op[3] = op_div;
    bus.req_valid = 4'b1000;
    tick();
    total++;
    if (bus.req_grant !== 4'b1000 || bus.fpu_start !== 1'b1) begin
      bad++;
      $display("FAIL to_grant got=%b/%b want=1000/1", bus.req_grant, bus.fpu_start);
    end
    bus.fpu_busy = 1'b1;
    cnt = 1;
    while (cnt < 20) begin
      tick();
      if (!bus.fpu_start) break;
      cnt++;
    end
    total++;
    if (cnt !== 8) begin
      bad++;
      $display("FAIL to_busy_cycles got=%0d want=8", cnt);
    end
    total++;
    if (bus.req_done !== 4'b1000 || bus.req_error !== 1'b1 || bus.result !== 32'h7fc0_0000) begin
      bad++;
      $display("FAIL to_abort got=%b/%b/%h want=1000/1/7fc00000", bus.req_done, bus.req_error, bus.result);
    end
    bus.req_a[0] = 32'h3f80_0000;
    bus.req_b[0] = 32'h0000_0000;
    bus.req_op[0] = op_add;
    bus.req_valid = 4'b0001;
    repeat (4) tick();
    total++;
    if (bus.req_grant !== 4'b0000 || bus.fpu_start !== 1'b0 || bus.req_done !== 4'b0000) begin
      bad++;
      $display("FAIL to_withheld got=%b/%b/%b want=0000/0/0000", bus.req_grant, bus.fpu_start, bus.req_done);
    end
    bus.fpu_busy = 1'b0;
    tick();
    total++;
    if (bus.req_grant !== 4'b0001 || bus.fpu_start !== 1'b1) begin
      bad++;
      $display("FAIL to_regrant got=%b/%b want=0001/1", bus.req_grant, bus.fpu_start);
    end
    bus.fpu_cmd_end = 1'b1;
    bus.fpu_result = 32'h3f80_0000;
    tick();
    bus.fpu_cmd_end = 1'b0;
    total++;
    if (bus.req_done !== 4'b0001 || bus.req_error !== 1'b0 || bus.result !== 32'h3f80_0000) begin
      bad++;
      $display("FAIL to_recover got=%b/%b/%h want=0001/0/3f800000", bus.req_done, bus.req_error, bus.result);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_simultaneous();
    bus.req_a[1] = 32'h4000_0000;
    bus.req_b[1] = 32'h4040_0000;
    bus.req_op[1] = op_add;
    bus.req_valid = 4'b0010;
    tick();
    total++;
    if (bus.req_grant !== 4'b0010) begin
      bad++;
      $display("FAIL sim_grant got=%b want=0010", bus.req_grant);
    end
    repeat (7) tick();
    total++;
    if (bus.fpu_start !== 1'b1) begin
      bad++;
      $display("FAIL sim_last_wd_cycle got=%b want=1", bus.fpu_start);
    end
    bus.fpu_cmd_end = 1'b1;
    bus.fpu_result = 32'h40a0_0000;
    tick();
    bus.fpu_cmd_end = 1'b0;
    total++;
    if (bus.req_done !== 4'b0010 || bus.req_error !== 1'b0 || bus.result !== 32'h40a0_0000) begin
      bad++;
      $display("FAIL sim_done_wins got=%b/%b/%h want=0010/0/40a00000", bus.req_done, bus.req_error, bus.result);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    bus.req_a[3] = 32'h4080_0000;
    bus.req_valid = 4'b1000;
    tick();
    total++;
    if (bus.req_grant !== 4'b1000) begin
      bad++;
      $display("FAIL rmb_grant got=%b want=1000", bus.req_grant);
    end
    tick();
    arst = 1'b1;
    bus.req_a[1] = 32'h1111_1111;
    bus.req_valid = 4'b1010;
    tick();
    total++;
    if (bus.fpu_start !== 1'b0 || bus.req_grant !== 4'b0000 || bus.req_done !== 4'b0000) begin
      bad++;
      $display("FAIL rmb_reset got=%b/%b/%b want=0/0000/0000", bus.fpu_start, bus.req_grant, bus.req_done);
    end
    arst = 1'b0;
    tick();
    total++;
    if (bus.req_grant !== 4'b0010 || bus.fpu_a !== 32'h1111_1111 || bus.req_done !== 4'b0000) begin
      bad++;
      $display("FAIL rmb_regrant got=%b/%h/%b want=0010/11111111/0000", bus.req_grant, bus.fpu_a, bus.req_done);
    end
    bus.fpu_cmd_end = 1'b1;
    bus.fpu_result = 32'h4110_0000;
    tick();
    bus.fpu_cmd_end = 1'b0;
    total++;
    if (bus.req_done !== 4'b0010 || bus.result !== 32'h4110_0000) begin
      bad++;
      $display("FAIL rmb_done got=%b/%h want=0010/41100000", bus.req_done, bus.result);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_rotation();
    test_timeout();
    test_simultaneous();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares the single fpu instance between N requesters (microcode sequencer, vector/DMA engines).
- Selects one pending request by round-robin and latches its operands and operation.
- Sequences the fpu start/cmd_end handshake, then returns the result and a one-cycle done pulse to the winner.
- A watchdog aborts any operation whose cmd_end never arrives, so a hung FPU cannot lock the bus.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 256, cycles allowed in BUSY before the operation is aborted (>=4).
- PTR_W, $clog2(N), width of the round-robin pointer (derived, not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- arst  input  1  reset, synchronous, active-high.
- req_valid  input  N  per-requester request; level held until that requester's req_done.
- req_a  input  N x 32  per-requester IEEE-754 operand A.
- req_b  input  N x 32  per-requester IEEE-754 operand B.
- req_op  input  N x pa_fpu::e_fpu_op  per-requester operation.
- req_grant  output  N  one-hot owner of the FPU; all-zero when idle.
- req_done  output  N  one-cycle pulse to the owner when its result is valid.
- req_error  output  1  qualifies req_done; 1 means aborted by timeout.
- result  output  32  registered result, valid with req_done, held until the next completion.
- fpu_start  output  1  to fpu start.
- fpu_a  output  32  to fpu a_operand, from latched registers.
- fpu_b  output  32  to fpu b_operand, from latched registers.
- fpu_op  output  pa_fpu::e_fpu_op  to fpu operation.
- fpu_result  input  32  from fpu ieee_packet_out.
- fpu_cmd_end  input  1  from fpu cmd_end; fpu_result is valid in any cycle where it is sampled high.
- fpu_busy  input  1  from fpu busy.

Behaviour:
- Reset values: req_grant=0, req_done=0, req_error=0, result=0, fpu_start=0, fpu_a=0, fpu_b=0, fpu_op=pa_fpu::op_add, RR pointer=0, state=IDLE, watchdog=0.
- Reset asserted in any state forces these values at the next edge; an in-flight op is dropped with no req_done.
- States: IDLE, BUSY, DONE, ABORT.
- IDLE:
  - If any req_valid bit is set and fpu_busy=0, select the first set bit scanning ptr, ptr+1, ... (mod N).
  - Latch that requester's a/b/op into fpu_a/fpu_b/fpu_op, set req_grant one-hot, clear watchdog, go to BUSY.
  - If fpu_busy=1, stay in IDLE.
  - Latency: req_valid seen at edge k -> fpu_start=1 from cycle k+1.
- BUSY:
  - fpu_start=1 and operand outputs stable for the whole state; watchdog increments each cycle.
  - fpu_cmd_end=1: capture fpu_result into result, go to DONE. Takes priority over timeout when both occur in the same cycle.
  - Watchdog reaching TIMEOUT-1 with no cmd_end: go to ABORT.
- DONE (one cycle):
  - fpu_start=0; req_done[owner]=1, req_error=0.
  - ptr <= owner+1 (mod N); req_grant cleared; go to IDLE.
- ABORT (one cycle):
  - fpu_start=0; result=32'h7FC00000 (quiet NaN); req_done[owner]=1, req_error=1.
  - ptr <= owner+1; go to IDLE. IDLE then waits for fpu_busy=0 before the next issue.
- Back-to-back throughput: one op per (FPU latency + 2) cycles; IDLE is always visited between ops.
- Owner dropping req_valid mid-op: the op still completes and req_done still pulses. Requests are never cancelled.
- Requests from non-owners are ignored while BUSY; their operand changes have no effect on the latched values.
- Fairness: with all N requesting continuously, grants rotate 0,1,..,N-1,0; no requester waits more than N-1 ops.
- The owner's req_valid is sampled again in IDLE after DONE. A requester must drop req_valid on req_done unless it has a new op ready.

Test Plan:
- Single request: req0 add 32'h3f800000 + 32'h3f8ccccd -> fpu_start high until cmd_end; req_done[0] one cycle; result=32'h40066666; req_error=0.
- Round-robin: req0..3 all held valid with 16.0+32.0 (32'h41800000, 32'h42000000) -> grants in order 0,1,2,3,0; each result=32'h42400000; exactly one req_done per op.
- Pointer rotation: after req1 completes, req0 and req2 assert in the same cycle -> req2 granted first. op_sub 32'h3e800000 - 32'h3f000000 -> result=32'hBE800000.
- Timeout: stub FPU never raises cmd_end, TIMEOUT=8 -> fpu_start drops after 8 BUSY cycles; req_done with req_error=1; result=32'h7FC00000. Next grant is withheld until the stub drops fpu_busy.
- Simultaneous cmd_end and timeout on the last watchdog cycle -> DONE path taken, req_error=0, FPU result returned.
- Reset mid-BUSY: arst for one cycle -> next edge fpu_start=0, req_grant=0, no req_done. A pending request is re-granted starting from requester 0.
